bin2bcd_serial: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits directly upstream of the seven-segment display driver: it accepts a binary sample with a valid strobe and produces a packed BCD word plus a one-cycle valid pulse. The display driver registers that word and multiplexes it onto the digits. It trades latency (NUM_BITS cycles) for a small, timing-friendly datapath.

---
 rtl/bin2bcd_serial.sv | 111 +++++++++++
 tb/tb_bin2bcd_serial.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro BIN2BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits to 4'hF.
module bin2bcd_serial #(
  parameter int NUM_BITS   = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_BITS-1:0]     binary_in,
  input  logic                    binary_in_valid,
  output logic [4*NUM_DIGITS-1:0] packed_bcd_out,
  output logic                    packed_bcd_out_valid,
  output logic                    busy,
  output logic                    overflow,
  output logic                    in_dropped
);

  localparam int BW = 4*NUM_DIGITS;
  localparam int SW = BW + NUM_BITS;
  localparam int CW = $clog2(NUM_BITS+1);
  localparam logic [NUM_BITS:0] MAX_VAL =
    (NUM_BITS+1)'(10**NUM_DIGITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   sreg;
  logic            ovf_q;
  logic [BW-1:0]   acc_adj;
  logic [SW-1:0]   shifted;
  logic [BW-1:0]   result;
  logic [BW-1:0]   out_word;
  logic [3:0]      digit;

  always_comb begin
    acc_adj = '0;
    digit   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = sreg[NUM_BITS+4*i +: 4];
      acc_adj[4*i +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
    shifted = {acc_adj, sreg[NUM_BITS-1:0]} << 1;
    result  = shifted[SW-1 -: BW];
  end

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  logic lead;

  // Digit 0 stays visible so a zero result still shows "0".
  always_comb begin
    lead     = 1'b1;
    out_word = ovf_q ? {NUM_DIGITS{4'h9}} : result;
    if (!ovf_q) begin
      for (int i = NUM_DIGITS-1; i > 0; i--) begin
        if (result[4*i +: 4] != 4'h0)
          lead = 1'b0;
        if (lead)
          out_word[4*i +: 4] = 4'hF;
      end
    end
  end
`else
  always_comb begin
    out_word = ovf_q ? {NUM_DIGITS{4'h9}} : result;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      cnt                  <= '0;
      sreg                 <= '0;
      ovf_q                <= 1'b0;
      packed_bcd_out       <= '0;
      packed_bcd_out_valid <= 1'b0;
      busy                 <= 1'b0;
      overflow             <= 1'b0;
      in_dropped           <= 1'b0;
    end else begin
      packed_bcd_out_valid <= 1'b0;
      in_dropped           <= 1'b0;
      unique case (state)
        IDLE: begin
          if (binary_in_valid) begin
            sreg  <= {{BW{1'b0}}, binary_in};
            cnt   <= CW'(NUM_BITS);
            ovf_q <= {1'b0, binary_in} > MAX_VAL;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (binary_in_valid)
            in_dropped <= 1'b1;
          sreg <= shifted;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            packed_bcd_out       <= out_word;
            packed_bcd_out_valid <= 1'b1;
            overflow             <= ovf_q;
            busy                 <= 1'b0;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial with immediate-assertion checks.
// Expected values follow BIN2BCD_LEADING_ZERO_BLANK_EN when defined.
module tb_bin2bcd_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] binary_in;
  logic        binary_in_valid;
  logic [15:0] packed_bcd_out;
  logic        packed_bcd_out_valid;
  logic        busy;
  logic        overflow;
  logic        in_dropped;

  int vectors     = 0;
  int miscompares = 0;

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  localparam logic [15:0] E0   = 16'hFFF0;
  localparam logic [15:0] E7   = 16'hFFF7;
  localparam logic [15:0] E42  = 16'hFF42;
  localparam logic [15:0] E500 = 16'hF500;
  localparam logic [15:0] E3   = 16'hFFF3;
  localparam logic [15:0] E77  = 16'hFF77;
`else
  localparam logic [15:0] E0   = 16'h0000;
  localparam logic [15:0] E7   = 16'h0007;
  localparam logic [15:0] E42  = 16'h0042;
  localparam logic [15:0] E500 = 16'h0500;
  localparam logic [15:0] E3   = 16'h0003;
  localparam logic [15:0] E77  = 16'h0077;
`endif

  bin2bcd_serial #(.NUM_BITS(14), .NUM_DIGITS(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .binary_in            (binary_in),
    .binary_in_valid      (binary_in_valid),
    .packed_bcd_out       (packed_bcd_out),
    .packed_bcd_out_valid (packed_bcd_out_valid),
    .busy                 (busy),
    .overflow             (overflow),
    .in_dropped           (in_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int v);
    logic [15:0] r;
    logic        lead;
    int          d;
    if (v > 9999) return 16'h9999;
    r = '0;
    d = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int i = 3; i > 0; i--) begin
      if (r[4*i +: 4] != 4'h0) lead = 1'b0;
      if (lead) r[4*i +: 4] = 4'hF;
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  task automatic start(input logic [13:0] v);
    @(negedge clk);
    binary_in       = v;
    binary_in_valid = 1'b1;
    @(posedge clk);
    #1;
    binary_in_valid = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_valid(output int lat, output int bsy);
    lat = 0;
    bsy = 0;
    while (packed_bcd_out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy === 1'b1 && packed_bcd_out_valid !== 1'b1) bsy++;
    end
  endtask

  task automatic convert(input string tag, input logic [13:0] v,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int lat, bsy;
    start(v);
    wait_valid(lat, bsy);
    chk({tag, "_latency"}, lat, 14);
    chk({tag, "_bcd"}, packed_bcd_out, exp_bcd);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_busy_low"}, busy, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse_end"}, packed_bcd_out_valid, 1'b0);
    chk({tag, "_hold"}, packed_bcd_out, exp_bcd);
  endtask

  initial begin
    int lat, bsy, nv;
    int vals[22];

    binary_in       = '0;
    binary_in_valid = 1'b0;
    reset           = 1'b1;
    #1;
    chk("rst_bcd", packed_bcd_out, 16'h0);
    chk("rst_valid", packed_bcd_out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_drop", in_dropped, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    start(14'd1234);
    wait_valid(lat, bsy);
    chk("c1234_latency", lat, 14);
    chk("c1234_busy_cycles", bsy + 1, 14);
    chk("c1234_bcd", packed_bcd_out, 16'h1234);
    chk("c1234_ovf", overflow, 1'b0);
    chk("c1234_busy_low", busy, 1'b0);

    convert("c9999", 14'd9999, 16'h9999, 1'b0);
    convert("c0", 14'd0, E0, 1'b0);
    convert("c7", 14'd7, E7, 1'b0);
    convert("c12345", 14'd12345, 16'h9999, 1'b1);
    convert("c42", 14'd42, E42, 1'b0);

    // Second valid 5 cycles into a conversion is dropped
    start(14'd500);
    repeat (4) @(posedge clk);
    @(negedge clk);
    binary_in       = 14'd3;
    binary_in_valid = 1'b1;
    @(posedge clk);
    #1;
    binary_in_valid = 1'b0;
    chk("drop_pulse", in_dropped, 1'b1);
    @(posedge clk);
    #1;
    chk("drop_pulse_end", in_dropped, 1'b0);
    wait_valid(lat, bsy);
    chk("drop_latency", lat, 8);
    chk("drop_bcd", packed_bcd_out, E500);
    start(14'd3);
    chk("k15_no_drop", in_dropped, 1'b0);
    wait_valid(lat, bsy);
    chk("k15_latency", lat, 14);
    chk("k15_bcd", packed_bcd_out, E3);

    // Asynchronous reset mid-conversion
    start(14'd8888);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_bcd", packed_bcd_out, 16'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_valid", packed_bcd_out_valid, 1'b0);
    chk("arst_ovf", overflow, 1'b0);
    chk("arst_drop", in_dropped, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (packed_bcd_out_valid === 1'b1) nv++;
    end
    chk("arst_no_valid", nv, 0);
    convert("c77", 14'd77, E77, 1'b0);

    // Back-to-back sweep at maximum rate
    vals[0] = 16383;
    vals[1] = 10000;
    vals[2] = 9999;
    vals[3] = 0;
    for (int i = 4; i < 22; i++) vals[i] = int'($urandom_range(16383, 0));
    @(negedge clk);
    binary_in       = 14'(vals[0]);
    binary_in_valid = 1'b1;
    for (int n = 0; n < 22; n++) begin
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (packed_bcd_out_valid !== 1'b1 && lat < 40);
      chk("sweep_spacing", lat, 15);
      chk("sweep_bcd", packed_bcd_out, model(vals[n]));
      chk("sweep_ovf", overflow, vals[n] > 9999);
      if (n < 21) binary_in = 14'(vals[n+1]);
      else binary_in_valid = 1'b0;
    end
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
